// File: rtl/sram_port_arbiter.sv
// Arbitrates NUM_MASTERS request ports onto one single-port SRAM with fixed-priority
// or round-robin selection, optional burst lock with a timeout, and a one-cycle read return.
module sram_port_arbiter #(
    parameter int NUM_MASTERS       = 3,
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int ARB_MODE          = 0,
    parameter int MAX_LOCK          = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NUM_MASTERS-1:0]                   req_i,
    input  logic [NUM_MASTERS-1:0]                   lock_i,
    input  logic [NUM_MASTERS-1:0]                   we_i,
    input  logic [NUM_MASTERS*MEMORY_ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_MASTERS*MEMORY_DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_MASTERS-1:0]                   gnt_o,
    output logic [NUM_MASTERS-1:0]                   rvalid_o,
    output logic [MEMORY_DATA_WIDTH-1:0]             rdata_o,
    output logic                                     busy_o,
    output logic                                     cen_o,
    output logic                                     wen_o,
    output logic [MEMORY_ADDR_WIDTH-1:0]             a_o,
    output logic [MEMORY_DATA_WIDTH-1:0]             d_o,
    input  logic [MEMORY_DATA_WIDTH-1:0]             q_i
);

    localparam int N     = NUM_MASTERS;
    localparam int AW    = MEMORY_ADDR_WIDTH;
    localparam int DW    = MEMORY_DATA_WIDTH;
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_GNT  = 1'b1
    } arb_state_e;

    arb_state_e       state_q;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     rvalid_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic             armed_q;

    logic [AW-1:0]    addr_arr  [N];
    logic [DW-1:0]    wdata_arr [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*AW +: AW];
            assign wdata_arr[gi] = wdata_i[gi*DW +: DW];
        end
    endgenerate

    // Index of the current grantee (gnt_q is one-hot or zero).
    logic [IDX_W-1:0] gnt_idx;
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    logic [N-1:0] access_vec;
    logic         accessing;
    assign access_vec = gnt_q & req_i;
    assign accessing  = |access_vec;

    always_comb begin
        cen_o = 1'b1;
        wen_o = 1'b1;
        a_o   = '0;
        d_o   = '0;
        if (accessing) begin
            cen_o = 1'b0;
            wen_o = ~we_i[gnt_idx];
            a_o   = addr_arr[gnt_idx];
            d_o   = wdata_arr[gnt_idx];
        end
    end

    // The grantee that just had its turn steps aside whenever anyone else is waiting.
    logic [N-1:0] others_vec;
    logic         others_req;
    logic [N-1:0] arb_req;
    assign others_vec = req_i & ~gnt_q;
    assign others_req = |others_vec;
    assign arb_req    = others_req ? others_vec : req_i;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = (ARB_MODE == 1) ? int'(ptr_q) + k : k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && arb_req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    logic [N-1:0]     win_onehot;
    logic [IDX_W-1:0] next_ptr;
    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
    assign next_ptr   = (win_idx == IDX_W'(N-1)) ? '0 : win_idx + 1'b1;

    // Lock expires only after MAX_LOCK locked cycles and only if someone else wants the port.
    logic             locked;
    logic [CNT_W:0]   lock_cnt_inc;
    logic             lock_reached;
    logic             hold_lock;
    assign locked       = (state_q == ARB_GNT) && |(gnt_q & lock_i);
    assign lock_cnt_inc = {1'b0, lock_cnt_q} + 1'b1;
    assign lock_reached = lock_cnt_inc >= (CNT_W+1)'(MAX_LOCK);
    assign hold_lock    = locked && !(lock_reached && others_req);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            rvalid_q <= access_vec & ~we_i;
            case (state_q)
                ARB_IDLE: begin
                    if (armed_q && win_found) begin
                        state_q    <= ARB_GNT;
                        gnt_q      <= win_onehot;
                        ptr_q      <= next_ptr;
                        lock_cnt_q <= '0;
                    end
                end
                ARB_GNT: begin
                    if (hold_lock) begin
                        lock_cnt_q <= lock_reached ? CNT_W'(MAX_LOCK) : lock_cnt_inc[CNT_W-1:0];
                    end else if (win_found) begin
                        gnt_q      <= win_onehot;
                        ptr_q      <= next_ptr;
                        lock_cnt_q <= '0;
                    end else begin
                        state_q    <= ARB_IDLE;
                        gnt_q      <= '0;
                        lock_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? q_i : '0;
    assign busy_o   = (state_q == ARB_GNT);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: a fixed-priority arbiter (MAX_LOCK=4) with an SRAM model, plus a round-robin arbiter.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [N-1:0]    req_f, lock_f, we_f;
    logic [N*AW-1:0] addr_f;
    logic [N*DW-1:0] wdata_f;
    logic [N-1:0]    gnt_f, rvalid_f;
    logic [DW-1:0]   rdata_f, d_f, q_f;
    logic            busy_f, cen_f, wen_f;
    logic [AW-1:0]   a_f;

    logic [N-1:0]    req_r, lock_r, we_r;
    logic [N*AW-1:0] addr_r;
    logic [N*DW-1:0] wdata_r;
    logic [N-1:0]    gnt_r, rvalid_r;
    logic [DW-1:0]   rdata_r, d_r, q_r;
    logic            busy_r, cen_r, wen_r;
    logic [AW-1:0]   a_r;

    assign lock_r  = '0;
    assign we_r    = '0;
    assign addr_r  = '0;
    assign wdata_r = '0;
    assign q_r     = '0;

    sram_port_arbiter #(.NUM_MASTERS(N), .MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW),
                        .ARB_MODE(0), .MAX_LOCK(4)) dut_fixed (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_f), .lock_i(lock_f), .we_i(we_f),
        .addr_i(addr_f), .wdata_i(wdata_f), .gnt_o(gnt_f), .rvalid_o(rvalid_f),
        .rdata_o(rdata_f), .busy_o(busy_f), .cen_o(cen_f), .wen_o(wen_f), .a_o(a_f),
        .d_o(d_f), .q_i(q_f));

    sram_port_arbiter #(.NUM_MASTERS(N), .MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW),
                        .ARB_MODE(1), .MAX_LOCK(16)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_r), .lock_i(lock_r), .we_i(we_r),
        .addr_i(addr_r), .wdata_i(wdata_r), .gnt_o(gnt_r), .rvalid_o(rvalid_r),
        .rdata_o(rdata_r), .busy_o(busy_r), .cen_o(cen_r), .wen_o(wen_r), .a_o(a_r),
        .d_o(d_r), .q_i(q_r));

    // SRAM model: synchronous, read data appears the cycle after the read.
    logic [DW-1:0] mem [512];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[9'h033] <= 8'h77;
            mem[9'h1A5] <= 8'h3C;
        end else if (!cen_f) begin
            if (!wen_f) mem[a_f] <= d_f;
            else        q_f <= mem[a_f];
        end
    end

    typedef struct packed { logic [AW-1:0] a; logic wen; logic [DW-1:0] d; } acc_t;
    typedef struct packed { logic [N-1:0] rv; logic [DW-1:0] data; } rd_t;

    logic [N-1:0] exp_gnt_f [$];
    acc_t         exp_acc_f [$];
    rd_t          exp_rd_f  [$];
    logic [N-1:0] exp_gnt_r [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no output", name, got);
    endtask

    logic [N-1:0] mon_g, mon_gr;
    acc_t         mon_acc;
    rd_t          mon_rd;
    always @(negedge clk) begin
        if (gnt_f != '0) begin
            if (exp_gnt_f.size() == 0) unexpected("gnt_f", 32'(gnt_f));
            else begin
                mon_g = exp_gnt_f.pop_front();
                chk("gnt_f", 32'(gnt_f), 32'(mon_g));
            end
        end
        if (!cen_f) begin
            if (exp_acc_f.size() == 0) unexpected("access {a,wen,d}", 32'({a_f, wen_f, d_f}));
            else begin
                mon_acc = exp_acc_f.pop_front();
                chk("access {a,wen,d}", 32'({a_f, wen_f, d_f}), 32'(mon_acc));
            end
        end
        if (rvalid_f != '0) begin
            if (exp_rd_f.size() == 0) unexpected("read {rvalid,rdata}", 32'({rvalid_f, rdata_f}));
            else begin
                mon_rd = exp_rd_f.pop_front();
                chk("read {rvalid,rdata}", 32'({rvalid_f, rdata_f}), 32'(mon_rd));
            end
        end
        if (gnt_r != '0) begin
            if (exp_gnt_r.size() == 0) unexpected("gnt_rr", 32'(gnt_r));
            else begin
                mon_gr = exp_gnt_r.pop_front();
                chk("gnt_rr", 32'(gnt_r), 32'(mon_gr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " gnt"},    32'(gnt_f),    32'h0);
        chk({tag, " rvalid"}, 32'(rvalid_f), 32'h0);
        chk({tag, " rdata"},  32'(rdata_f),  32'h0);
        chk({tag, " busy"},   32'(busy_f),   32'h0);
        chk({tag, " cen"},    32'(cen_f),    32'h1);
        chk({tag, " wen"},    32'(wen_f),    32'h1);
        chk({tag, " a"},      32'(a_f),      32'h0);
        chk({tag, " d"},      32'(d_f),      32'h0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, " pending grants"},   32'(exp_gnt_f.size()), 32'h0);
        chk({tag, " pending accesses"}, 32'(exp_acc_f.size()), 32'h0);
        chk({tag, " pending reads"},    32'(exp_rd_f.size()),  32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        req_f   = 3'b111;
        lock_f  = '0;
        we_f    = '0;
        addr_f  = '0;
        wdata_f = '0;
        req_r   = '0;
        repeat (3) tick();
        @(negedge clk);
        check_reset("in_reset");

        // Reset release with master 0 already requesting a read of 0x033.
        tick();
        rst_n = 1'b1;
        req_f = 3'b001;
        addr_f[0*AW +: AW]  = 9'h033;
        wdata_f[0*DW +: DW] = 8'h5A;
        exp_gnt_f.push_back(3'b001);
        exp_gnt_f.push_back(3'b001);
        exp_acc_f.push_back('{a: 9'h033, wen: 1'b1, d: 8'h5A});
        exp_rd_f.push_back('{rv: 3'b001, data: 8'h77});
        tick();
        @(negedge clk);
        chk("no grant on first edge after reset", 32'(gnt_f), 32'h0);
        tick();
        tick();
        req_f = 3'b000;
        repeat (3) tick();
        check_drained("release");

        // Master 1 writes A5 to 0x010, master 2 reads 0x1A5 (Q = 3C).
        req_f = 3'b110;
        we_f  = 3'b010;
        addr_f[1*AW +: AW]  = 9'h010;
        wdata_f[1*DW +: DW] = 8'hA5;
        addr_f[2*AW +: AW]  = 9'h1A5;
        wdata_f[2*DW +: DW] = 8'hC3;
        exp_gnt_f.push_back(3'b010);
        exp_gnt_f.push_back(3'b100);
        exp_gnt_f.push_back(3'b100);
        exp_acc_f.push_back('{a: 9'h010, wen: 1'b0, d: 8'hA5});
        exp_acc_f.push_back('{a: 9'h1A5, wen: 1'b1, d: 8'hC3});
        exp_rd_f.push_back('{rv: 3'b100, data: 8'h3C});
        tick();
        tick();
        req_f[1] = 1'b0;
        tick();
        req_f[2] = 1'b0;
        repeat (3) tick();
        check_drained("priority");

        // Locked write burst by master 0 times out after 4 cycles; master 1 reads back 0x010.
        we_f   = 3'b001;
        lock_f = 3'b001;
        addr_f[0*AW +: AW]  = 9'h100;
        wdata_f[0*DW +: DW] = 8'h11;
        wdata_f[1*DW +: DW] = 8'h96;
        req_f  = 3'b011;
        repeat (4) begin
            exp_gnt_f.push_back(3'b001);
            exp_acc_f.push_back('{a: 9'h100, wen: 1'b0, d: 8'h11});
        end
        exp_gnt_f.push_back(3'b010);
        exp_acc_f.push_back('{a: 9'h010, wen: 1'b1, d: 8'h96});
        exp_gnt_f.push_back(3'b001);
        exp_acc_f.push_back('{a: 9'h100, wen: 1'b0, d: 8'h11});
        exp_gnt_f.push_back(3'b001);
        exp_rd_f.push_back('{rv: 3'b010, data: 8'hA5});
        repeat (6) tick();
        req_f[1] = 1'b0;
        tick();
        req_f  = 3'b000;
        lock_f = 3'b000;
        repeat (3) tick();
        check_drained("lock");

        // Reset asserted during master 2's read grant cycle.
        we_f  = 3'b000;
        req_f = 3'b100;
        exp_gnt_f.push_back(3'b100);
        exp_acc_f.push_back('{a: 9'h1A5, wen: 1'b1, d: 8'hC3});
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_read_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_f = 3'b000;
        tick();
        @(negedge clk);
        chk("rvalid after reset release", 32'(rvalid_f), 32'h0);
        repeat (3) tick();
        check_drained("abort");

        // Round-robin rotation with all three masters requesting continuously.
        req_r = 3'b111;
        exp_gnt_r.push_back(3'b001);
        exp_gnt_r.push_back(3'b010);
        exp_gnt_r.push_back(3'b100);
        exp_gnt_r.push_back(3'b001);
        repeat (4) tick();
        req_r = 3'b000;
        repeat (3) tick();
        chk("rr pending grants", 32'(exp_gnt_r.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
